clock_sequencer: RTL

CLOCK_SEQUENCER -- requirements
Module: clock_sequencer

---
 rtl/clock_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/clock_sequencer.sv
// Power-up clock/reset sequencer: waits for a stable PLL lock, releases channel
// resets one at a time, then runs a phase accumulator per channel to make clock enables.
module clock_sequencer #(
    parameter int NUM_CH          = 2,
    parameter int ACC_W           = 24,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int RST_STAGGER     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_lock,
    input  logic [NUM_CH*ACC_W-1:0]   inc,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      lost_clr,
    output logic [NUM_CH-1:0]         ch_rst_n,
    output logic [NUM_CH-1:0]         ce,
    output logic                      ready,
    output logic                      lock_lost,
    output logic [1:0]                dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0]      CNT_LAST  = 16'(LOCK_STABLE_CYC - 1);
    localparam logic [7:0]       STAG_LAST = 8'(RST_STAGGER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [15:0]        cnt, cnt_nx;
    logic [7:0]         stag, stag_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [NUM_CH-1:0]  rst_nx;
    logic               lock_m, lock_s;
    logic               lost_set;

    // pll_lock is asynchronous to clk; only lock_s is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    assign lost_set = (state != WAIT_LOCK) && !lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            stag      <= '0;
            idx       <= '0;
            ch_rst_n  <= '0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            stag      <= stag_nx;
            idx       <= idx_nx;
            ch_rst_n  <= rst_nx;
            // a new loss wins over a coincident clear
            lock_lost <= lost_set | (lock_lost & ~lost_clr);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stag_nx  = stag;
        idx_nx   = idx;
        case (state)
            WAIT_LOCK: begin
                cnt_nx  = '0;
                stag_nx = '0;
                idx_nx  = '0;
                if (lock_s) state_nx = STABLE;
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                    stag_nx  = '0;
                    idx_nx   = '0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    stag_nx  = '0;
                    idx_nx   = '0;
                end else if (idx == IDX_LAST) begin
                    state_nx = RUN;
                end else if (stag == STAG_LAST) begin
                    idx_nx  = idx + 1'b1;
                    stag_nx = '0;
                end else begin
                    stag_nx = stag + 8'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nx = WAIT_LOCK;
                    stag_nx  = '0;
                    idx_nx   = '0;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    // Channel resets are registered from the next state so they move on the same edge as state
    always_comb begin
        rst_nx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state_nx == RELEASE)
                rst_nx[i] = (i <= int'(idx_nx));
            else if (state_nx == RUN)
                rst_nx[i] = 1'b1;
        end
        ready     = (state == RUN);
        dbg_state = state;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             ce_r;

        assign sum = {1'b0, acc} + {1'b0, inc[g*ACC_W +: ACC_W]};

        // Accumulator stays at zero on the release edge and whenever the channel is (re)entering reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc  <= '0;
                ce_r <= 1'b0;
            end else if (!rst_nx[g] || !ch_rst_n[g]) begin
                acc  <= '0;
                ce_r <= 1'b0;
            end else if (ch_en[g]) begin
                acc  <= sum[ACC_W-1:0];
                ce_r <= sum[ACC_W];
            end else begin
                ce_r <= 1'b0;
            end
        end

        assign ce[g] = ce_r;
    end

endmodule
